// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: BOOT/RUN/HALT control, redirect arbitration, flush and redirect counting.
// Optional exception support is enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] EXC_VECTOR = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_one,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted,
  output logic [15:0] redirect_count,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, pc_inc;
  logic                    flush_q, flush_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    redirect;
  logic                    exc_take;

  assign pc_inc = pc_q + ADDR_WIDTH'(1);

`ifdef PC_SEQ_EXC_EN
  assign exc_take = exc;
`else
  assign exc_take = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redirect = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (exc_take) begin
          pc_d     = EXC_VECTOR[ADDR_WIDTH-1:0];
          redirect = 1'b1;
        end else if (jump) begin
          pc_d     = jump_target[ADDR_WIDTH-1:0];
          redirect = 1'b1;
        end else if (branch_taken) begin
          pc_d     = branch_target[ADDR_WIDTH-1:0];
          redirect = 1'b1;
        end else if (halt) begin
          state_d = HALT;
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
      HALT: begin
        if (exc_take) begin
          pc_d     = EXC_VECTOR[ADDR_WIDTH-1:0];
          redirect = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign flush_d = redirect;
  assign cnt_d   = (redirect && (cnt_q != '1)) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC[ADDR_WIDTH-1:0];
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_SEQ_EXC_EN
  logic [ADDR_WIDTH-1:0] epc_q;

  // exc_take only produces a redirect outside BOOT, so gate capture the same way
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      epc_q <= '0;
    end else if (exc_take && (state_q != BOOT)) begin
      epc_q <= pc_q;
    end
  end

  assign epc = 32'(epc_q);
`else
  logic unused_exc;
  assign unused_exc = exc;
  assign epc        = '0;
`endif

  generate
    if (ADDR_WIDTH < 32) begin : g_unused_hi
      logic unused_target_hi;
      assign unused_target_hi = ^{branch_target[31:ADDR_WIDTH], jump_target[31:ADDR_WIDTH]};
    end
  endgenerate

  assign pc             = 32'(pc_q);
  assign pc_plus_one    = 32'(pc_inc);
  assign fetch_valid    = (state_q == RUN) && !flush_q;
  assign flush          = flush_q;
  assign halted         = (state_q == HALT);
  assign redirect_count = cnt_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that owns the program counter register and decides its next value every cycle. It arbitrates between sequential increment, branch, jump and stall requests from the pipeline. It also produces the fetch-valid and flush qualifiers consumed by the IF/ID latch. It sits between the instruction memory address port and the decode/execute redirect logic.

## Interface

Parameters:
- ADDR_WIDTH, 12, number of live PC bits; upper bits of all 32-bit PC outputs read 0.
- RESET_PC, 0, PC value loaded on reset.
- EXC_VECTOR, 1, exception handler address; used only with PC_SEQ_EXC_EN.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- stall  input  1  hold PC (hazard from decode).
- branch_taken  input  1  take branch_target this cycle.
- branch_target  input  32  branch destination; only low ADDR_WIDTH bits used.
- jump  input  1  take jump_target this cycle (j, jal, jr).
- jump_target  input  32  jump destination; low ADDR_WIDTH bits used.
- halt  input  1  freeze fetch permanently until reset.
- exc  input  1  exception request; ignored without PC_SEQ_EXC_EN.
- pc  output  32  current fetch address, zero-extended.
- pc_plus_one  output  32  (pc + 1) mod 2^ADDR_WIDTH, zero-extended; combinational from pc.
- fetch_valid  output  1  instruction at pc is on the correct path and may enter IF/ID.
- flush  output  1  registered one-cycle pulse: kill the instruction currently in IF/ID.
- halted  output  1  sequencer is in HALT.
- redirect_count  output  16  saturating count of accepted redirects.
- epc  output  32  PC of the excepting instruction; 0 without PC_SEQ_EXC_EN.

## Operation

- States: BOOT, RUN, HALT.
- BOOT: entered on reset. pc=RESET_PC, fetch_valid=0. Leaves unconditionally to RUN on the first rising edge after reset deasserts. pc is unchanged on that edge.
- RUN: fetch_valid=1 except in the cycle flush is high (fetch_valid=0 then).
- RUN next-PC priority, highest first:
  1. exc (when enabled): pc<=EXC_VECTOR, epc<=pc.
  2. jump: pc<=jump_target.
  3. branch_taken: pc<=branch_target.
  4. halt: pc holds, go to HALT.
  5. stall: pc holds.
  6. Otherwise: pc<=pc_plus_one.
- Priorities 1–3 are redirects. Each accepted redirect sets flush for the following cycle and increments redirect_count.
- Redirects override stall and halt presented in the same cycle. Stall is dropped, not remembered. Halt is dropped.
- HALT: pc frozen, fetch_valid=0, halted=1, flush=0.
  - Leaves only on reset.
  - With PC_SEQ_EXC_EN, exc also leaves HALT: redirect to EXC_VECTOR, return to RUN, same flush and counter rules.
- All requests are ignored in BOOT.
- Wrap-around: pc_plus_one of 2^ADDR_WIDTH-1 is 0. Targets are truncated, never range-checked.
- redirect_count saturates at 16'hFFFF.

## Timing

- Reset values: pc=RESET_PC, pc_plus_one=RESET_PC+1, fetch_valid=0, flush=0, halted=0, redirect_count=0, epc=0, state=BOOT.
- Reset asserted mid-operation (any state, including mid-flush) forces the reset values asynchronously, within the same cycle.
- Redirect latency: request sampled at edge N; pc=target and flush=1 during cycle N+1; flush=0 from N+2 unless another redirect was accepted at N+1.
- Back-to-back redirects are all accepted; flush stays high continuously.
- Stall latency 0: pc does not change on any edge where stall is sampled high with no redirect.
- halt sampled at edge N: halted=1 and fetch_valid=0 from cycle N+1.

## Configuration

- PC_SEQ_EXC_EN defined:
  - exc input is live with top priority.
  - epc register captures the faulting pc.
  - exc exits HALT.
- Undefined:
  - exc is ignored.
  - epc is tied to 0.
  - EXC_VECTOR is unused.
  - No epc flops are synthesised.

## Test plan

- Reset release, no requests, RESET_PC=0: BOOT one cycle with fetch_valid=0; then pc=0,1,2,3 on successive cycles; fetch_valid=1 from cycle 2.
- stall high 3 cycles at pc=5 with branch_taken=1, target=40 in the second stall cycle: pc 5,5,40; flush=1 in the pc=40 cycle; redirect_count=1.
- jump=1 (target 100) and branch_taken=1 (target 200) together at pc=7: pc=100 next; one flush pulse; redirect_count=1.
- ADDR_WIDTH=12, free-running from pc=4094: pc 4094, 4095, 0, 1; pc_plus_one=0 while pc=4095.
- halt at pc=9: halted=1, pc frozen at 9, fetch_valid=0 for 10 cycles. Async reset mid-cycle: pc=RESET_PC and halted=0 immediately.
- With PC_SEQ_EXC_EN, exc and jump together at pc=12, EXC_VECTOR=1: pc=1 and epc=12 next cycle, one flush pulse. Repeat from HALT: returns to RUN at pc=1.
